uart_word_loader: RTL and testbench
===================================

UART_WORD_LOADER -- requirements
Module: uart_word_loader

Interface
REQ-001 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port start  input  1  one-cycle load request, sampled in IDLE only.
REQ-004 SHALL have port base_addr  input  18  first RAM2 word address, captured on accepted start.
REQ-005 SHALL have port word_count  input  16  number of 16-bit words to load, captured on accepted start.
REQ-006 SHALL have ports data_ready, tbre, tsre  input  1 each  UART receive-ready, transmit-buffer-empty and transmit-shift-empty flags.
REQ-007 SHALL have ports rdn, wrn  output  1 each  UART read and write strobes, active-low.
REQ-008 SHALL have port uart_data  inout  8  UART byte bus (RAM1 low byte lines); high-Z except when driving an echo byte.
REQ-009 SHALL have ports ram1EN, ram1OE, ram1WE  output  1 each  held 1 (RAM1 disabled, UART owns the bus).
REQ-010 SHALL have ports ram_addr2  output  18, ram_data2  inout  16, ram2EN, ram2OE, ram2WE  output  1 each  RAM2 interface, controls active-low.
REQ-011 SHALL have ports busy, done  output  1 each, and led  output  16  last word written.

Function
REQ-012 SHALL implement states IDLE, RX_WAIT, RX_STROBE, RX_LATCH, TX_DRIVE, TX_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-013 SHALL leave IDLE on start=1: captures base_addr/word_count, busy=1; word_count=0 -> DONE directly.
REQ-014 SHALL stay in RX_WAIT until data_ready=1, then drive rdn=0 for exactly 2 cycles (RX_STROBE), latching uart_data on the second.
REQ-015 SHALL in RX_LATCH raise rdn=1 and store the byte: first byte of a word -> low byte, second -> high byte.
REQ-016 SHALL go RX_LATCH -> RX_WAIT after a low byte and -> WR_SETUP after a high byte (echo off).
REQ-017 SHALL in WR_SETUP drive ram_addr2, ram_data2, ram2EN=0, ram2OE=1, ram2WE=1; WR_PULSE drives ram2WE=0 for 1 cycle; WR_HOLD returns ram2WE=1, data held.
REQ-018 SHALL after WR_HOLD update led with the word, increment address, decrement remaining count; remaining=0 -> DONE, else RX_WAIT.
REQ-019 SHALL wrap address 0x3FFFF -> 0x00000 with no error.
REQ-020 SHALL keep ram_data2 high-Z and ram2EN=1 outside WR_SETUP..WR_HOLD.
REQ-021 SHALL in DONE assert done=1, busy=0 for exactly one cycle, then go to IDLE.
REQ-022 SHALL ignore start while busy=1; data_ready outside RX_WAIT SHALL be ignored (byte remains pending in UART).
REQ-023 SHALL keep rdn and wrn never both 0 in the same cycle.

Reset
REQ-024 SHALL on rst=1 at a clock edge enter IDLE regardless of state, including mid-strobe or mid-write.
REQ-025 SHALL reset outputs: rdn=1, wrn=1, ram2EN/OE/WE=1, ram1EN/OE/WE=1, uart_data and ram_data2 high-Z, ram_addr2=0, busy=0, done=0, led=0.
REQ-026 SHALL discard a partially assembled word on reset; no RAM write is completed after rst.

Configuration
REQ-027 SHALL use macro UART_ECHO_EN: when defined, after each RX_LATCH go to TX_DRIVE (drive uart_data=byte, wrn=0 for 1 cycle), then TX_WAIT until tbre=1 and tsre=1, then continue per REQ-016.
REQ-028 SHALL without UART_ECHO_EN omit TX_DRIVE/TX_WAIT, hold wrn=1, and never drive uart_data.

Verification
REQ-029 SHALL cover: start, base_addr=0x00100, word_count=2, bytes 0x34,0x12,0xCD,0xAB -> RAM2[0x100]=0x1234, RAM2[0x101]=0xABCD, led=0xABCD, one done pulse.
REQ-030 SHALL cover: word_count=0 -> done within 2 cycles of start, no rdn or ram2WE activity.
REQ-031 SHALL cover: base_addr=0x3FFFF, word_count=2 -> writes to 0x3FFFF then 0x00000.
REQ-032 SHALL cover: rst asserted during WR_PULSE -> next cycle ram2WE=1, IDLE, busy=0; new start loads correctly from word 0.
REQ-033 SHALL cover: start pulsed while busy -> ignored, captured word_count unchanged.
REQ-034 SHALL cover (UART_ECHO_EN): byte 0x5A received -> wrn=0 one cycle with uart_data=0x5A; loader stalls while tbre=0 for 10 cycles, resumes when tbre=tsre=1.

Source files
------------

// File: rtl/uart_word_loader.sv
// Receives little-endian byte pairs from a UART and writes them as 16-bit words into RAM2.
// Defining UART_ECHO_EN adds an echo of every received byte back to the UART transmitter.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start; all buses released
// RX_WAIT   | waiting for UART data_ready
// RX_STROBE | rdn low for two cycles, byte latched on the second
// RX_LATCH  | rdn released, byte placed in low or high half of the word
// TX_DRIVE  | echo only: byte on uart_data, wrn low for one cycle
// TX_WAIT   | echo only: wait for tbre and tsre
// WR_SETUP  | RAM2 selected, address and data driven
// WR_PULSE  | ram2WE low for one cycle
// WR_HOLD   | ram2WE high again, data held; bookkeeping on exit
// DONE      | one-cycle done pulse
module uart_word_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [17:0] base_addr,
  input  logic [15:0] word_count,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre,
  output logic        rdn,
  output logic        wrn,
  inout  wire  [7:0]  uart_data,
  output logic        ram1EN,
  output logic        ram1OE,
  output logic        ram1WE,
  output logic [17:0] ram_addr2,
  inout  wire  [15:0] ram_data2,
  output logic        ram2EN,
  output logic        ram2OE,
  output logic        ram2WE,
  output logic        busy,
  output logic        done,
  output logic [15:0] led
);

  typedef enum logic [3:0] {
    IDLE, RX_WAIT, RX_STROBE, RX_LATCH, TX_DRIVE,
    TX_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;

  state_t      state, state_nxt;
  logic        strobe_2nd;
  logic        byte_hi;
  logic [7:0]  rx_byte;
  logic [15:0] word_q;
  logic [17:0] addr_q;
  logic [15:0] remaining;
  logic        ram_drive;
  logic        uart_drive;

  // RAM2 data is write-only here and the TX flags only matter with echo enabled
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ram_data2, tbre, tsre};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      strobe_2nd <= 1'b0;
      byte_hi    <= 1'b0;
      rx_byte    <= 8'h00;
      word_q     <= 16'h0000;
      addr_q     <= 18'h00000;
      remaining  <= 16'h0000;
      led        <= 16'h0000;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q    <= base_addr;
            remaining <= word_count;
            byte_hi   <= 1'b0;
          end
        end
        RX_STROBE: begin
          strobe_2nd <= ~strobe_2nd;
          if (strobe_2nd) rx_byte <= uart_data;
        end
        RX_LATCH: begin
          if (byte_hi) word_q[15:8] <= rx_byte;
          else         word_q[7:0]  <= rx_byte;
          byte_hi <= ~byte_hi;
        end
        WR_HOLD: begin
          led       <= word_q;
          addr_q    <= addr_q + 18'd1;
          remaining <= remaining - 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    rdn        = 1'b1;
    wrn        = 1'b1;
    ram2EN     = 1'b1;
    ram2OE     = 1'b1;
    ram2WE     = 1'b1;
    ram_drive  = 1'b0;
    uart_drive = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (word_count == 16'd0) ? DONE : RX_WAIT;
      end
      RX_WAIT: begin
        if (data_ready) state_nxt = RX_STROBE;
      end
      RX_STROBE: begin
        rdn = 1'b0;
        if (strobe_2nd) state_nxt = RX_LATCH;
      end
      RX_LATCH: begin
`ifdef UART_ECHO_EN
        state_nxt = TX_DRIVE;
`else
        state_nxt = byte_hi ? WR_SETUP : RX_WAIT;
`endif
      end
`ifdef UART_ECHO_EN
      TX_DRIVE: begin
        wrn        = 1'b0;
        uart_drive = 1'b1;
        state_nxt  = TX_WAIT;
      end
      TX_WAIT: begin
        // byte_hi has already toggled: set means a low byte was just taken
        if (tbre && tsre) state_nxt = byte_hi ? RX_WAIT : WR_SETUP;
      end
`endif
      WR_SETUP: begin
        ram2EN    = 1'b0;
        ram_drive = 1'b1;
        state_nxt = WR_PULSE;
      end
      WR_PULSE: begin
        ram2EN    = 1'b0;
        ram2WE    = 1'b0;
        ram_drive = 1'b1;
        state_nxt = WR_HOLD;
      end
      WR_HOLD: begin
        ram2EN    = 1'b0;
        ram_drive = 1'b1;
        state_nxt = (remaining == 16'd1) ? DONE : RX_WAIT;
      end
      DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ram1EN    = 1'b1;
  assign ram1OE    = 1'b1;
  assign ram1WE    = 1'b1;
  assign ram_addr2 = addr_q;
  assign ram_data2 = ram_drive ? word_q : 16'hzzzz;
  assign uart_data = uart_drive ? rx_byte : 8'hzz;

endmodule

// File: tb/tb_uart_word_loader.sv
// Self-checking bench for uart_word_loader: a UART byte source, a RAM2 model and an expected-write queue.
// Build with UART_ECHO_EN defined to also exercise the echo path.
`timescale 1ns/1ps
module tb_uart_word_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [17:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        data_ready = 1'b0;
  logic        tbre = 1'b1;
  logic        tsre = 1'b1;
  logic        rdn, wrn, ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE, busy, done;
  logic [17:0] ram_addr2;
  logic [15:0] led;
  wire  [7:0]  uart_data;
  wire  [15:0] ram_data2;

  logic        drive_en = 1'b0;
  logic [7:0]  tb_byte = 8'h00;
  assign uart_data = drive_en ? tb_byte : 8'hzz;

  uart_word_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .rdn(rdn), .wrn(wrn),
    .uart_data(uart_data), .ram1EN(ram1EN), .ram1OE(ram1OE), .ram1WE(ram1WE),
    .ram_addr2(ram_addr2), .ram_data2(ram_data2), .ram2EN(ram2EN), .ram2OE(ram2OE),
    .ram2WE(ram2WE), .busy(busy), .done(done), .led(led)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [17:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] exp_led = 16'h0000;
  logic [7:0]  tx_q[$];
  logic [15:0] mem [logic [17:0]];

  int rdn_len = 0, we_len = 0, wrn_len = 0;
  int rdn_pulses = 0, we_pulses = 0, done_pulses = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rd(input logic [17:0] a);
    return mem.exists(a) ? mem[a] : 16'hxxxx;
  endfunction

  always @(posedge clk)
    if (!ram2EN && !ram2WE) mem[ram_addr2] = ram_data2;

  // Protocol monitor and expected-write scoreboard
  always @(negedge clk) begin
    wr_t w;
    if (rst) begin
      rdn_len = 0; we_len = 0; wrn_len = 0; prev_done = 1'b0;
    end else begin
      check("rdn_wrn_exclusive", 32'(!rdn && !wrn), 32'd0);
      check("ram1_disabled", 32'({ram1EN, ram1OE, ram1WE}), 32'd7);
      check("ram2OE_high", 32'(ram2OE), 32'd1);
      if (!busy) check("idle_ram2EN", 32'(ram2EN), 32'd1);
      if (!rdn) rdn_len++;
      else if (rdn_len != 0) begin
        check("rdn_width", rdn_len, 32'd2);
        rdn_pulses++;
        rdn_len = 0;
      end
      if (!ram2WE) begin
        we_len++;
        check("we_with_en", 32'(ram2EN), 32'd0);
        if (we_len == 1) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write: addr %0h data %0h, none expected", ram_addr2, ram_data2);
          end else begin
            w = exp_q.pop_front();
            check("write_addr", 32'(ram_addr2), 32'(w.a));
            check("write_data", 32'(ram_data2), 32'(w.d));
            exp_led = w.d;
          end
        end
      end else if (we_len != 0) begin
        check("we_width", we_len, 32'd1);
        we_pulses++;
        we_len = 0;
      end
`ifdef UART_ECHO_EN
      if (!wrn) begin
        wrn_len++;
        check("echo_byte", 32'(uart_data), 32'(tb_byte));
      end else if (wrn_len != 0) begin
        check("wrn_width", wrn_len, 32'd1);
        wrn_len = 0;
      end
`else
      check("wrn_idle", 32'(wrn), 32'd1);
`endif
      if (done) begin
        check("done_busy_low", 32'(busy), 32'd0);
        check("done_single", 32'(prev_done), 32'd0);
        check("done_led", 32'(led), 32'(exp_led));
        check("done_all_written", exp_q.size(), 32'd0);
        done_pulses++;
      end
      prev_done = done;
    end
  end

  task automatic push_exp(input logic [17:0] base, input int cnt);
    wr_t w;
    for (int i = 0; i < cnt; i++) begin
      w.a = 18'(base + 18'(i));
      w.d = {tx_q[2*i+1], tx_q[2*i]};
      exp_q.push_back(w);
    end
  endtask

  task automatic pulse_start(input logic [17:0] b, input logic [15:0] c);
    base_addr = b; word_count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    tb_byte = b; drive_en = 1'b1; data_ready = 1'b1;
    n = 0;
    while (rdn !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      tests++; fails++;
      $display("FAIL rx_timeout: rdn never fell for byte %0h", b);
    end
    data_ready = 1'b0;
    n = 0;
    while (rdn !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    drive_en = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    if (n >= budget) begin
      tests++; fails++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic run_load(input logic [17:0] base, input logic [15:0] cnt);
    int n;
    push_exp(base, int'(cnt));
    pulse_start(base, cnt);
    foreach (tx_q[i]) send_byte(tx_q[i]);
    wait_done(100, n);
    @(negedge clk);
  endtask

  initial begin
    int n, d0, r0, w0;
    repeat (3) @(negedge clk);
    check("rst_rdn", 32'(rdn), 32'd1);
    check("rst_wrn", 32'(wrn), 32'd1);
    check("rst_ram2_ctl", 32'({ram2EN, ram2OE, ram2WE}), 32'd7);
    check("rst_addr", 32'(ram_addr2), 32'd0);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // two words from 0x100
    tx_q = '{8'h34, 8'h12, 8'hCD, 8'hAB};
    d0 = done_pulses;
    run_load(18'h00100, 16'd2);
    check("basic_word0", 32'(rd(18'h00100)), 32'h1234);
    check("basic_word1", 32'(rd(18'h00101)), 32'hABCD);
    check("basic_led", 32'(led), 32'hABCD);
    check("basic_done_count", done_pulses - d0, 32'd1);
    check("basic_idle_after", 32'(busy), 32'd0);

    // zero words: straight to done, no strobes
    r0 = rdn_pulses; w0 = we_pulses; d0 = done_pulses;
    tx_q.delete();
    pulse_start(18'h00055, 16'd0);
    wait_done(3, n);
    check("zero_done_in_2", 32'(n <= 1), 32'd1);
    @(negedge clk);
    repeat (2) @(negedge clk);
    check("zero_no_rdn", rdn_pulses - r0, 32'd0);
    check("zero_no_we", we_pulses - w0, 32'd0);
    check("zero_done_count", done_pulses - d0, 32'd1);
    check("zero_led_kept", 32'(led), 32'hABCD);

    // address wrap
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(18'h3FFFF, 16'd2);
    check("wrap_top", 32'(rd(18'h3FFFF)), 32'h0201);
    check("wrap_zero", 32'(rd(18'h00000)), 32'h0403);
    check("wrap_led", 32'(led), 32'h0403);

    // start while busy is ignored
    tx_q = '{8'h78, 8'h56, 8'hBC, 8'h9A};
    d0 = done_pulses;
    push_exp(18'h00400, 2);
    pulse_start(18'h00400, 16'd2);
    send_byte(8'h78);
    check("ign_busy", 32'(busy), 32'd1);
    pulse_start(18'h00000, 16'd5);
    send_byte(8'h56); send_byte(8'hBC); send_byte(8'h9A);
    wait_done(100, n);
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("ign_word0", 32'(rd(18'h00400)), 32'h5678);
    check("ign_word1", 32'(rd(18'h00401)), 32'h9ABC);
    check("ign_done_count", done_pulses - d0, 32'd1);
    check("ign_no_restart", 32'(busy), 32'd0);

    // reset during WR_PULSE
    tx_q = '{8'hEF, 8'hBE};
    push_exp(18'h00200, 1);
    pulse_start(18'h00200, 16'd2);
    send_byte(8'hEF); send_byte(8'hBE);
    n = 0;
    while (ram2WE !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check("rstw_reached_pulse", 32'(n < 20), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_we_high", 32'(ram2WE), 32'd1);
    check("rstw_en_high", 32'(ram2EN), 32'd1);
    check("rstw_busy", 32'({busy, done}), 32'd0);
    check("rstw_led", 32'(led), 32'd0);
    check("rstw_addr", 32'(ram_addr2), 32'd0);
    rst = 1'b0;
    exp_q.delete(); exp_led = 16'h0000;
    @(negedge clk);

    // reset with half a word received, then a clean load
    pulse_start(18'h00210, 16'd1);
    send_byte(8'h77);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); exp_led = 16'h0000;
    @(negedge clk);
    tx_q = '{8'h11, 8'h22};
    run_load(18'h00600, 16'd1);
    check("after_rst_word", 32'(rd(18'h00600)), 32'h2211);
    check("after_rst_led", 32'(led), 32'h2211);
    check("after_rst_no_partial", 32'(mem.exists(18'h00210)), 32'd0);

`ifdef UART_ECHO_EN
    tx_q = '{8'h5A, 8'hA5};
    push_exp(18'h00500, 1);
    pulse_start(18'h00500, 16'd1);
    tbre = 1'b0;
    send_byte(8'h5A);
    @(negedge clk);
    check("echo_wrn_low", 32'(wrn), 32'd0);
    check("echo_data", 32'(uart_data), 32'h5A);
    data_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("echo_stall_rdn", 32'(rdn), 32'd1);
      check("echo_stall_wrn", 32'(wrn), 32'd1);
    end
    tbre = 1'b1;
    send_byte(8'hA5);
    wait_done(100, n);
    @(negedge clk);
    check("echo_word", 32'(rd(18'h00500)), 32'hA55A);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
